// File: rtl/jb_aes_pkg.sv
// rtl/jb_aes_pkg.sv - shared types, key-size helpers and GF(2^8) xtime for the AES key expander
package jb_aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef logic [31:0] word_t;

    function automatic int nk_of(input int key_width);
        return key_width / 32;
    endfunction

    function automatic int nr_of(input int key_width);
        return nk_of(key_width) + 6;
    endfunction

    function automatic int nwords_of(input int key_width);
        return 4 * (nr_of(key_width) + 1);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/jb_aes_sbox.sv
// rtl/jb_aes_sbox.sv - combinational AES forward S-box lookup
module jb_aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Entry for input x sits at bits [8*(255-x) +: 8], i.e. row-major from the MSB.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/jb_aes_subword.sv
// rtl/jb_aes_subword.sv - SubWord: S-box applied to each byte of a 32-bit word
module jb_aes_subword
    import jb_aes_pkg::*;
(
    input  word_t w_in,
    output word_t w_out
);

    genvar g;
    for (g = 0; g < 4; g++) begin : g_sbox
        jb_aes_sbox u_sbox (
            .a (w_in[8*g +: 8]),
            .y (w_out[8*g +: 8])
        );
    end

endmodule

// File: rtl/jb_aes_key_expand.sv
// rtl/jb_aes_key_expand.sv - streaming AES key schedule; JB_AES_KEYEXP_RESTART_EN allows restart mid-run
module jb_aes_key_expand
    import jb_aes_pkg::*;
#(
    parameter int KEY_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic                 nStart,
    input  logic [KEY_WIDTH-1:0] key,
    input  logic                 rk_ready,
    output logic                 rk_valid,
    output word_t                rk_word,
    output logic [5:0]           rk_index,
    output logic                 busy,
    output logic                 nDone
);

    localparam int         NK        = nk_of(KEY_WIDTH);
    localparam logic [5:0] LAST_IDX  = 6'(nwords_of(KEY_WIDTH) - 1);
    localparam logic [2:0] PHASE_MAX = 3'(NK - 1);

    state_e                 state_q, state_d;
    logic [KEY_WIDTH-1:0]   win_q, win_d;
    logic [7:0]             rcon_q, rcon_d;
    logic [2:0]             phase_q, phase_d;
    logic [5:0]             idx_q, idx_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   ndone_q, ndone_d;
    logic                   start_req;
    word_t                  first_w, last_w, sub_in, sub_out, temp_w, next_w;

`ifdef JB_AES_KEYEXP_RESTART_EN
    assign start_req = !nStart;
`else
    assign start_req = !nStart && (state_q == ST_IDLE);
`endif

    // Window holds w[i..i+Nk-1]; the head is the presented word, the tail feeds the next one.
    assign first_w = win_q[KEY_WIDTH-1 -: 32];
    assign last_w  = win_q[31:0];
    assign sub_in  = (phase_q == 3'd0) ? {last_w[23:0], last_w[31:24]} : last_w;

    jb_aes_subword u_subword (
        .w_in  (sub_in),
        .w_out (sub_out)
    );

    always_comb begin
        temp_w = last_w;
        if (phase_q == 3'd0) begin
            temp_w = sub_out ^ {rcon_q, 24'h0};
        end else if ((NK == 8) && (phase_q == 3'd4)) begin
            temp_w = sub_out;
        end
        next_w = first_w ^ temp_w;
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        rcon_d  = rcon_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        ndone_d = 1'b1;
        if (start_req) begin
            state_d = ST_STREAM;
            win_d   = key;
            rcon_d  = 8'h01;
            phase_d = 3'd0;
            idx_d   = 6'd0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ST_STREAM: begin
                    if (valid_q && rk_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                            valid_d = 1'b0;
                            ndone_d = 1'b0;
                        end else begin
                            win_d   = {win_q[KEY_WIDTH-33:0], next_w};
                            idx_d   = idx_q + 6'd1;
                            phase_d = (phase_q == PHASE_MAX) ? 3'd0 : phase_q + 3'd1;
                            if (phase_q == 3'd0) begin
                                rcon_d = xtime(rcon_q);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            rcon_q  <= 8'h01;
            phase_q <= 3'd0;
            idx_q   <= 6'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ndone_q <= 1'b1;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            rcon_q  <= rcon_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ndone_q <= ndone_d;
        end
    end

    assign rk_valid = valid_q;
    assign rk_word  = first_w;
    assign rk_index = idx_q;
    assign busy     = busy_q;
    assign nDone    = ndone_q;

endmodule
